// File: rtl/cic_pkg.sv
// Shared widths and clamp helpers for the CIC output path.
// Default full width is CIC_WIN + CIC_WG. The gain-compensation shift equals the
// CIC growth CIC_WG, which maps the integrator output back onto CIC_WIN.
package cic_pkg;

    localparam int CIC_WIN   = 16;
    localparam int CIC_WG    = 22;
    localparam int CIC_WOUT  = 16;
    localparam int CIC_SHIFT = CIC_WG;

    // Largest value representable in a w-bit two's complement word.
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Most negative value representable in a w-bit two's complement word.
    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/fwft_fifo.sv
// First-word-fall-through FIFO: the head entry is always visible on rdata.
// A write into a full FIFO is accepted only when a read happens in the same cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module fwft_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         not_empty,
    output logic         full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          wr_en;
    logic          rd_en;

    assign full      = (count == CW'(DEPTH));
    assign not_empty = (count != '0);
    assign rdata     = mem[rd_ptr];
    assign rd_en     = pop & not_empty;
    assign wr_en     = push & (~full | rd_en);

    // Storage, pointers and occupancy; the storage is cleared so the head reads 0 in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cic_out_scaler.sv
// CIC output scaler: round-half-up arithmetic shift, saturation to WOUT, FWFT buffer.
// Optional build macro CIC_OUT_SCALER_SATCNT_EN adds the sat_cnt saturation counter.
//
// Handshake toward the sink: a sample transfers on every rising edge where
// val_out and o_ready are both high; while val_out is high and o_ready is low,
// o_data and val_out hold. The input side has no ready: val_in may be high
// every cycle, and samples arriving at a full buffer that is not being read are dropped.
module cic_out_scaler
    import cic_pkg::*;
#(
    parameter int WIN   = CIC_WIN + CIC_WG,
    parameter int WOUT  = CIC_WOUT,
    parameter int SHIFT = CIC_SHIFT,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            val_in,
    input  logic [WIN-1:0]  i_data,
    input  logic            o_ready,
    input  logic            clr_flags,
    output logic            val_out,
    output logic [WOUT-1:0] o_data,
    output logic            sat_flag,
    output logic            ovf_flag
`ifdef CIC_OUT_SCALER_SATCNT_EN
    ,
    output logic [15:0]     sat_cnt
`endif
);

    // Width of the shifted value: one guard bit above the input, minus the dropped LSBs.
    localparam int SW = WIN + 1 - SHIFT;
    localparam logic [WIN:0]           RND    = (WIN + 1)'(1) << (SHIFT - 1);
    localparam logic signed [SW-1:0]   LIM_HI = SW'(sat_max(WOUT));
    localparam logic signed [SW-1:0]   LIM_LO = SW'(sat_min(WOUT));

    logic [WIN:0]           r1;
    logic                   v1;
    logic signed [SW-1:0]   s;
    logic [WOUT-1:0]        res;
    logic                   clamp;
    logic [WOUT-1:0]        d2;
    logic                   v2;
    logic                   sat2;
    logic                   pop;
    logic                   full;
    logic                   drop;
    logic                   rnd_residue_unused;

    // Stage 1: add half an output LSB in a sign-extended word so the sum cannot wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r1 <= '0;
            v1 <= 1'b0;
        end else begin
            r1 <= {i_data[WIN-1], i_data} + RND;
            v1 <= val_in;
        end
    end

    // Keeping the top bits is the arithmetic shift; the low bits are only rounding residue.
    assign s                  = r1[WIN:SHIFT];
    assign rnd_residue_unused = ^r1[SHIFT-1:0];

    // Clamp the shifted value to the signed WOUT range.
    always_comb begin
        clamp = 1'b0;
        res   = s[WOUT-1:0];
        if (s > LIM_HI) begin
            clamp = 1'b1;
            res   = LIM_HI[WOUT-1:0];
        end else if (s < LIM_LO) begin
            clamp = 1'b1;
            res   = LIM_LO[WOUT-1:0];
        end
    end

    // Stage 2: register the saturated sample and whether it was clamped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d2   <= '0;
            v2   <= 1'b0;
            sat2 <= 1'b0;
        end else begin
            d2   <= res;
            v2   <= v1;
            sat2 <= v1 & clamp;
        end
    end

    assign pop  = val_out & o_ready;
    assign drop = v2 & full & ~pop;

    fwft_fifo #(
        .W     (WOUT),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (v2),
        .wdata     (d2),
        .pop       (pop),
        .rdata     (o_data),
        .not_empty (val_out),
        .full      (full)
    );

    // Sticky flags; a set event in the same cycle overrides the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            if (clr_flags) begin
                sat_flag <= 1'b0;
                ovf_flag <= 1'b0;
            end
            if (sat2) begin
                sat_flag <= 1'b1;
            end
            if (drop) begin
                ovf_flag <= 1'b1;
            end
        end
    end

`ifdef CIC_OUT_SCALER_SATCNT_EN
    // Saturating count of clamped samples; an increment alongside a clear restarts at 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_cnt <= '0;
        end else if (sat2) begin
            if (clr_flags) begin
                sat_cnt <= 16'd1;
            end else if (sat_cnt != 16'hFFFF) begin
                sat_cnt <= sat_cnt + 16'd1;
            end
        end else if (clr_flags) begin
            sat_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_cic_out_scaler.sv
// Bench for cic_out_scaler: directed spec cases plus random traffic against
// a cycle-level transaction model (scaled value computed with integer arithmetic).
module tb_cic_out_scaler;

    localparam int WIN   = 38;
    localparam int WOUT  = 16;
    localparam int SHIFT = 22;
    localparam int DEPTH = 4;
    localparam longint LSB = 64'sd4194304;

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            val_in = 1'b0;
    logic [WIN-1:0]  i_data = '0;
    logic            o_ready = 1'b0;
    logic            clr_flags = 1'b0;
    logic            val_out;
    logic [WOUT-1:0] o_data;
    logic            sat_flag;
    logic            ovf_flag;
`ifdef CIC_OUT_SCALER_SATCNT_EN
    logic [15:0]     sat_cnt;
`endif

    always #5 clk = ~clk;

    cic_out_scaler #(
        .WIN   (WIN),
        .WOUT  (WOUT),
        .SHIFT (SHIFT),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .val_in    (val_in),
        .i_data    (i_data),
        .o_ready   (o_ready),
        .clr_flags (clr_flags),
        .val_out   (val_out),
        .o_data    (o_data),
        .sat_flag  (sat_flag),
        .ovf_flag  (ovf_flag)
`ifdef CIC_OUT_SCALER_SATCNT_EN
        ,
        .sat_cnt   (sat_cnt)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [WOUT-1:0] exp_q[$];
    logic            pv [2];
    logic [WOUT-1:0] pd [2];
    logic            ps [2];
    logic            m_sat;
    logic            m_ovf;
    int              m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [WIN-1:0] v38(input longint x);
        return x[WIN-1:0];
    endfunction

    // Expected {saturated, value}: floor((x + LSB/2) / LSB) clamped to WOUT bits.
    function automatic logic [WOUT:0] ref_scale(input logic [WIN-1:0] d);
        longint x;
        longint q;
        logic   sat;
        x   = longint'($signed(d));
        q   = (x + LSB / 2) >>> SHIFT;
        sat = 1'b0;
        if (q > 32767) begin
            q   = 32767;
            sat = 1'b1;
        end else if (q < -32768) begin
            q   = -32768;
            sat = 1'b1;
        end
        return {sat, q[WOUT-1:0]};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
            ps[i] = 1'b0;
        end
        m_sat = 1'b0;
        m_ovf = 1'b0;
        m_cnt = 0;
    endtask

    // One rising edge of the reference: 2-cycle scaler latency, then a DEPTH-entry queue.
    task automatic model_edge(input logic v, input logic [WIN-1:0] d, input logic rdy, input logic clr);
        logic          drop;
        logic [WOUT:0] r;
        drop = 1'b0;
        if (exp_q.size() != 0 && rdy) begin
            void'(exp_q.pop_front());
        end
        if (pv[1]) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(pd[1]);
            else drop = 1'b1;
        end
        if (clr) begin
            m_sat = 1'b0;
            m_ovf = 1'b0;
            m_cnt = 0;
        end
        if (ps[1]) begin
            m_sat = 1'b1;
            if (m_cnt < 65535) m_cnt++;
        end
        if (drop) m_ovf = 1'b1;
        pv[1] = pv[0];
        pd[1] = pd[0];
        ps[1] = ps[0];
        r     = ref_scale(d);
        pv[0] = v;
        pd[0] = r[WOUT-1:0];
        ps[0] = v & r[WOUT];
    endtask

    task automatic check_outputs();
        check("val_out", {31'd0, val_out}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            check("o_data", {16'd0, o_data}, {16'd0, exp_q[0]});
        end
        check("sat_flag", {31'd0, sat_flag}, {31'd0, m_sat});
        check("ovf_flag", {31'd0, ovf_flag}, {31'd0, m_ovf});
`ifdef CIC_OUT_SCALER_SATCNT_EN
        check("sat_cnt", {16'd0, sat_cnt}, m_cnt);
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic v, input logic [WIN-1:0] d, input logic rdy, input logic clr);
        @(negedge clk);
        check_outputs();
        val_in    = v;
        i_data    = d;
        o_ready   = rdy;
        clr_flags = clr;
        @(posedge clk);
        model_edge(v, d, rdy, clr);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        val_in    = 1'b0;
        clr_flags = 1'b0;
        rst       = 1'b0;
        #1;
        check("rst_val_out", {31'd0, val_out}, 32'd0);
        check("rst_o_data", {16'd0, o_data}, 32'd0);
        check("rst_sat_flag", {31'd0, sat_flag}, 32'd0);
        check("rst_ovf_flag", {31'd0, ovf_flag}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Single sample with o_ready high: visible on the third edge, gone after one more.
    task automatic send_check(input string tag, input logic [WIN-1:0] d, input logic [WOUT-1:0] exp);
        step(1'b1, d, 1'b1, 1'b0);
        idle(2, 1'b1);
        #1;
        check({tag, "_val"}, {31'd0, val_out}, 32'd1);
        check(tag, {16'd0, o_data}, {16'd0, exp});
        idle(1, 1'b1);
        #1;
        check({tag, "_gone"}, {31'd0, val_out}, 32'd0);
    endtask

    function automatic logic [WIN-1:0] rand_sample();
        int     mode;
        longint x;
        mode = $urandom_range(0, 3);
        case (mode)
            0:       x = longint'({$urandom(), $urandom()});
            1:       x = (longint'($urandom_range(0, 80000)) - 40000) * LSB
                         + longint'($urandom_range(0, 4194303));
            2:       x = (longint'($urandom_range(0, 200)) - 100) * LSB + LSB / 2;
            default: x = longint'($urandom_range(0, 2000)) - 1000;
        endcase
        return x[WIN-1:0];
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        #3;
        check("init_val_out", {31'd0, val_out}, 32'd0);
        check("init_o_data", {16'd0, o_data}, 32'd0);
        check("init_sat_flag", {31'd0, sat_flag}, 32'd0);
        check("init_ovf_flag", {31'd0, ovf_flag}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // rounding and latency
        send_check("round_1", v38(LSB), 16'h0001);
        send_check("round_p1p5", v38(LSB + LSB / 2), 16'h0002);
        send_check("round_m1p5", v38(-(LSB + LSB / 2)), 16'hFFFF);

        // saturation
        send_check("sat_pos", v38((64'sd1 <<< 37) - 1), 16'h7FFF);
        check("sat_flag_set", {31'd0, sat_flag}, 32'd1);
        send_check("sat_neg", v38(-(64'sd1 <<< 37)), 16'h8000);
        step(1'b0, '0, 1'b1, 1'b1);
        #1;
        check("sat_flag_clr", {31'd0, sat_flag}, 32'd0);

        // backpressure and overflow
        for (int k = 1; k <= 5; k++) step(1'b1, v38(k * LSB), 1'b0, 1'b0);
        idle(2, 1'b0);
        #1;
        check("bp_ovf", {31'd0, ovf_flag}, 32'd1);
        check("bp_head", {16'd0, o_data}, 32'd1);
        idle(5, 1'b1);
        #1;
        check("bp_empty", {31'd0, val_out}, 32'd0);
        step(1'b0, '0, 1'b1, 1'b1);

        // full with simultaneous push and pop
        for (int k = 0; k < 6; k++) step(1'b1, v38((10 + k) * LSB), 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) step(1'b1, v38((20 + k) * LSB), 1'b1, 1'b0);
        idle(8, 1'b1);
        #1;
        check("full_pp_no_ovf", {31'd0, ovf_flag}, 32'd0);

        // reset mid-stream: 3 buffered, 2 in flight
        step(1'b1, v38((64'sd1 <<< 37) - 1), 1'b0, 1'b0);
        step(1'b1, v38(2 * LSB), 1'b0, 1'b0);
        step(1'b1, v38(3 * LSB), 1'b0, 1'b0);
        step(1'b1, v38(4 * LSB), 1'b0, 1'b0);
        step(1'b1, v38(5 * LSB), 1'b0, 1'b0);
        do_reset();
        send_check("post_rst", v38(7 * LSB), 16'h0007);

`ifdef CIC_OUT_SCALER_SATCNT_EN
        step(1'b0, '0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, v38(-(64'sd1 <<< 37) + k), 1'b1, 1'b0);
        idle(3, 1'b1);
        #1;
        check("satcnt_3", {16'd0, sat_cnt}, 32'd3);
        step(1'b1, v38((64'sd1 <<< 37) - 1), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        #1;
        check("satcnt_clr_inc", {16'd0, sat_cnt}, 32'd1);
        idle(3, 1'b1);
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, rand_sample(),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end
        idle(8, 1'b1);
        @(negedge clk);
        check_outputs();

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
